// File: rtl/audio_mixer.sv
// Audio mixer: mixes SuperSprite, Mockingboard and Apple speaker sources
// into a stereo 16-bit unsigned stream at AUDIO_RATE, with per-source
// attenuation, saturation, sticky clip flags and speaker idle muting.
module audio_mixer #(
  parameter int unsigned CLOCK_SPEED_HZ   = 54_000_000,
  parameter int unsigned AUDIO_RATE       = 44100,
  parameter int unsigned SPK_IDLE_SAMPLES = 4096
) (
  input  logic        clk_logic,
  input  logic        device_reset_n,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic [3:0]  vol_ssp_i,
  input  logic [3:0]  vol_mb_i,
  input  logic [3:0]  vol_spk_i,
  input  logic        clip_clr_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        sample_valid_o,
  output logic        clip_l_o,
  output logic        clip_r_o
);

  localparam int unsigned ACC_W = $clog2(2 * CLOCK_SPEED_HZ + 1);
  localparam int unsigned CNT_W = $clog2(SPK_IDLE_SAMPLES + 1);
  localparam int unsigned SUM_W = 18;

  localparam logic [ACC_W-1:0] RATE_INC = ACC_W'(AUDIO_RATE);
  localparam logic [ACC_W-1:0] CLK_MOD  = ACC_W'(CLOCK_SPEED_HZ);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(SPK_IDLE_SAMPLES);
  localparam logic [15:0]      SPK_LVL  = 16'h2000;
  localparam logic [15:0]      SAT_MAX  = 16'hFFFF;

  // Snapshot of every source and control taken on a sample tick
  typedef struct packed {
    logic [15:0] ssp;
    logic [9:0]  mb_l;
    logic [9:0]  mb_r;
    logic        spk_lvl;
    logic        spk_act;
    logic [3:0]  vol_ssp;
    logic [3:0]  vol_mb;
    logic [3:0]  vol_spk;
  } cap_t;

  // Right shift by volume; the top volume code is a hard mute
  function automatic logic [15:0] atten(input logic [15:0] v, input logic [3:0] vol);
    logic [15:0] r;
    r = 16'h0;
    if (vol != 4'hF) begin
      r = v >> vol;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Sample tick generator
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q;
  logic             tick_q;
  logic [ACC_W-1:0] acc_sum_c;
  logic [ACC_W-1:0] acc_nxt_c;
  logic             tick_c;

  // Phase accumulator next value and tick decision
  always_comb begin
    acc_sum_c = acc_q + RATE_INC;
    tick_c    = 1'b0;
    acc_nxt_c = acc_sum_c;
    if (acc_sum_c >= CLK_MOD) begin
      tick_c    = 1'b1;
      acc_nxt_c = acc_sum_c - CLK_MOD;
    end
  end

  // Accumulator and one-cycle tick register
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_nxt_c;
      tick_q <= tick_c;
    end
  end

  // ---------------------------------------------------------------------
  // Speaker activity tracking
  // ---------------------------------------------------------------------
  logic             spk_prev_q;
  logic             chg_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic             chg_eff_c;
  logic [CNT_W-1:0] idle_nxt_c;
  logic             spk_active_c;

  // A change seen in the tick cycle itself counts toward that tick
  always_comb begin
    chg_eff_c  = chg_q | (speaker_i ^ spk_prev_q);
    idle_nxt_c = idle_cnt_q;
    if (chg_eff_c) begin
      idle_nxt_c = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_nxt_c = idle_cnt_q + CNT_W'(1);
    end
    spk_active_c = (idle_nxt_c < IDLE_MAX);
  end

  // Edge history, pending-change flag and idle counter
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      spk_prev_q <= 1'b0;
      chg_q      <= 1'b0;
      idle_cnt_q <= IDLE_MAX;
    end else begin
      spk_prev_q <= speaker_i;
      if (tick_q) begin
        chg_q      <= 1'b0;
        idle_cnt_q <= idle_nxt_c;
      end else begin
        chg_q <= chg_eff_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: capture sources on the tick
  // ---------------------------------------------------------------------
  cap_t cap_q;
  logic v1_q;

  // Freeze all inputs for this sample
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      cap_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= tick_q;
      if (tick_q) begin
        cap_q.ssp     <= ssp_audio_i;
        cap_q.mb_l    <= mb_audio_l_i;
        cap_q.mb_r    <= mb_audio_r_i;
        cap_q.spk_lvl <= speaker_i;
        cap_q.spk_act <= spk_active_c;
        cap_q.vol_ssp <= vol_ssp_i;
        cap_q.vol_mb  <= vol_mb_i;
        cap_q.vol_spk <= vol_spk_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: scale and attenuate each source
  // ---------------------------------------------------------------------
  logic [15:0] t_ssp_q;
  logic [15:0] t_mbl_q;
  logic [15:0] t_mbr_q;
  logic [15:0] t_spk_q;
  logic        v2_q;
  logic [15:0] spk_raw_c;

  // Speaker contributes only while it is both high and recently active
  always_comb begin
    spk_raw_c = 16'h0;
    if (cap_q.spk_lvl && cap_q.spk_act) begin
      spk_raw_c = SPK_LVL;
    end
  end

  // Attenuated terms
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      t_ssp_q <= '0;
      t_mbl_q <= '0;
      t_mbr_q <= '0;
      t_spk_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        t_ssp_q <= atten(cap_q.ssp, cap_q.vol_ssp);
        t_mbl_q <= atten(16'({cap_q.mb_l, 5'b0}), cap_q.vol_mb);
        t_mbr_q <= atten(16'({cap_q.mb_r, 5'b0}), cap_q.vol_mb);
        t_spk_q <= atten(spk_raw_c, cap_q.vol_spk);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: sum, saturate, publish
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0] sum_l_c;
  logic [SUM_W-1:0] sum_r_c;
  logic             ovf_l_c;
  logic             ovf_r_c;

  // Wide per-channel sums with overflow detect
  always_comb begin
    sum_l_c = SUM_W'(t_ssp_q) + SUM_W'(t_mbl_q) + SUM_W'(t_spk_q);
    sum_r_c = SUM_W'(t_ssp_q) + SUM_W'(t_mbr_q) + SUM_W'(t_spk_q);
    ovf_l_c = (sum_l_c[SUM_W-1:16] != '0);
    ovf_r_c = (sum_r_c[SUM_W-1:16] != '0);
  end

  // Output samples, strobe and sticky clip flags (a new clip beats a clear)
  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      audio_l_o      <= '0;
      audio_r_o      <= '0;
      sample_valid_o <= 1'b0;
      clip_l_o       <= 1'b0;
      clip_r_o       <= 1'b0;
    end else begin
      sample_valid_o <= v2_q;
      clip_l_o       <= (clip_l_o & ~clip_clr_i) | (v2_q & ovf_l_c);
      clip_r_o       <= (clip_r_o & ~clip_clr_i) | (v2_q & ovf_r_c);
      if (v2_q) begin
        audio_l_o <= ovf_l_c ? SAT_MAX : sum_l_c[15:0];
        audio_r_o <= ovf_r_c ? SAT_MAX : sum_r_c[15:0];
      end
    end
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 The module SHALL take parameter CLOCK_SPEED_HZ, default 54_000_000, which is the clk_logic frequency in Hz.
REQ-002 The module SHALL take parameter AUDIO_RATE, default 44100, which is the output sample rate in Hz.
REQ-003 The module SHALL take parameter SPK_IDLE_SAMPLES, default 4096, which is the number of sample ticks without a speaker change before the speaker is muted.
REQ-004 The module SHALL have port clk_logic, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 The module SHALL have port device_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port ssp_audio_i, input, 16 bits: SuperSprite audio, unsigned.
REQ-007 The module SHALL have ports mb_audio_l_i and mb_audio_r_i, input, 10 bits each: Mockingboard left and right audio, unsigned.
REQ-008 The module SHALL have port speaker_i, input, 1 bit: Apple speaker level.
REQ-009 The module SHALL have ports vol_ssp_i, vol_mb_i and vol_spk_i, input, 4 bits each: attenuation in 6 dB steps; 15 means mute.
REQ-010 The module SHALL have port clip_clr_i, input, 1 bit: a one-cycle pulse that clears the clip flags.
REQ-011 The module SHALL have ports audio_l_o and audio_r_o, output, 16 bits each: mixed unsigned samples, held between updates.
REQ-012 The module SHALL have port sample_valid_o, output, 1 bit: a one-cycle pulse when audio_l_o and audio_r_o update.
REQ-013 The module SHALL have ports clip_l_o and clip_r_o, output, 1 bit each: sticky saturation flags.

Function
REQ-014 The tick generator SHALL run a phase accumulator acc.
- Each cycle: acc += AUDIO_RATE.
- If the sum is >= CLOCK_SPEED_HZ: subtract CLOCK_SPEED_HZ and assert internal tick for one cycle.
- Accumulator width SHALL hold 2*CLOCK_SPEED_HZ without overflow.
REQ-015 The pipeline SHALL be three stages after tick at cycle T:
- T+1: capture all inputs.
- T+2: attenuate.
- T+3: sum, saturate, update outputs and pulse sample_valid_o.
- Latency is exactly 3 cycles.
REQ-016 Source scaling SHALL be as follows, with each term right-shifted by its volume and volume 15 forcing the term to 0:
- SSP term = ssp_audio_i.
- MB term = {mb_audio_x_i, 5'b0}.
- Speaker term = 16'h2000 when the captured speaker level is 1 and the speaker is active, else 0.
REQ-017 The sum per channel SHALL be the SSP term plus the MB term plus the speaker term, computed at 18 bits.
- If the result is > 16'hFFFF, output 16'hFFFF and set that channel's clip flag.
- Otherwise output the sum.
REQ-018 Speaker change detection SHALL compare speaker_i against its previous-cycle value every cycle and latch any difference into a change flag; the flag clears on the tick that consumes it.
REQ-019 The idle counter SHALL operate as follows:
- On each tick, a set change flag resets the counter to 0; otherwise the counter increments, saturating at SPK_IDLE_SAMPLES.
- The speaker is active while counter < SPK_IDLE_SAMPLES.
REQ-020 The change flag SHALL be set by a change that coincides with a tick, and that tick SHALL use the new flag value.
REQ-021 Clip flags SHALL be sticky until clip_clr_i.
- If clip_clr_i and a new clip occur in the same cycle, the flag SHALL end set.
REQ-022 The module SHALL never produce two ticks within fewer than floor(CLOCK_SPEED_HZ/AUDIO_RATE) cycles.

Reset
REQ-023 While device_reset_n is low, the module SHALL hold the following values:
- acc, all pipeline registers, audio_l_o, audio_r_o: 0.
- sample_valid_o, clip_l_o, clip_r_o: 0.
- Change flag: 0.
- Idle counter: SPK_IDLE_SAMPLES, so the speaker is inactive.
REQ-024 Assertion of reset mid-pipeline SHALL discard in-flight samples, and the first sample_valid_o after release SHALL follow a full tick period plus 3 cycles.

Verification
REQ-025 Tick spacing:
- Stimulus: default parameters, 1,000,000 cycles.
- Required: 816 or 817 pulses; every interval is 1224 or 1225 cycles.
REQ-026 Mix, no clip:
- Stimulus: ssp=16'h1000, mb_l=10'h100, all volumes 0, speaker idle.
- Required: audio_l_o=16'h3000, clip_l_o=0.
REQ-027 Saturation:
- Stimulus: ssp=16'hF000, mb_r=10'h3FF, volumes 0.
- Required: audio_r_o=16'hFFFF, clip_r_o=1.
- Then: clip_clr_i with inputs zeroed → clip_r_o=0.
REQ-028 Attenuation:
- Stimulus: ssp=16'h8000, vol_ssp=2, others mute.
- Required: 16'h2000.
- Then: vol_ssp=15 → 0.
REQ-029 Speaker idle:
- Stimulus: toggle speaker_i once, then hold it at 1, vol_spk=0.
- Required: speaker term 16'h2000 for 4096 samples after the change, then 0.
- Then: a single 1-cycle glitch between ticks re-activates the speaker.
REQ-030 Reset mid-operation:
- Stimulus: assert device_reset_n low 1 cycle after tick.
- Required: no sample_valid_o at T+3; all outputs 0 until the next post-reset sample.
